// File: rtl/qpsk_modulator_stream.sv
// Streaming QPSK modulator: serial bits -> (E, O) symbols -> FIFO -> phase-continuous
// I/Q carrier samples, SPS clocks per symbol, gap-free while data and enable are present.
module qpsk_modulator_stream #(
    parameter int DATA_W     = 12,
    parameter int AMP        = 1000,
    parameter int LUT_AW     = 7,
    parameter int PHASE_STEP = 1,
    parameter int SPS        = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   Clk,
    input  logic                                   Rst,
    input  logic                                   bit_in,
    input  logic                                   bit_valid,
    output logic                                   bit_ready,
    input  logic                                   en,
    output logic signed [DATA_W-1:0]               I_out,
    output logic signed [DATA_W-1:0]               Q_out,
    output logic signed [DATA_W:0]                 data_out,
    output logic                                   sym_strobe,
    output logic                                   active,
    output logic                                   underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level
);

    localparam int  LUT_N  = 1 << LUT_AW;
    localparam int  CNT_W  = $clog2(SPS);
    localparam int  LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int  PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam real TWO_PI = 6.283185307179586;

    typedef enum logic {IDLE, RUN} state_t;

    // ------------------------------------------------------------------
    // Sine table, rounded half away from zero; cosine reuses it a quarter
    // period ahead.
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] sin_lut [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam real S = real'(AMP) * $sin(TWO_PI * real'(k) / real'(LUT_N));
        localparam int  V = (S >= 0.0) ? $rtoi(S + 0.5) : $rtoi(S - 0.5);
        assign sin_lut[k] = DATA_W'(V);
    end

    // ------------------------------------------------------------------
    // Bit pairing and symbol FIFO
    // ------------------------------------------------------------------
    logic             have_e;
    logic             e_bit;
    logic             accept;
    logic             push;
    logic             pop;
    logic [1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic [1:0]       fifo_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full is judged on the registered level, so a same-cycle pop never frees room.
    assign bit_ready  = (fifo_cnt != LVL_W'(FIFO_DEPTH));
    assign accept     = bit_valid && bit_ready;
    assign push       = accept && have_e;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_head  = fifo_mem[rd_ptr];
    assign fifo_level = fifo_cnt;

    // NOTE: payload storage has no reset; the level and pointers alone define validity.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {e_bit, bit_in};
        end
    end

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            have_e   <= 1'b0;
            e_bit    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (accept) begin
                have_e <= !have_e;
                if (!have_e) begin
                    e_bit <= bit_in;
                end
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + LVL_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - LVL_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Symbol sequencer
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [LUT_AW-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cur_e_q, cur_e_d;
    logic              cur_o_q, cur_o_d;
    logic              emit;
    logic              strobe_d;
    logic              underrun_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        cur_e_d    = cur_e_q;
        cur_o_d    = cur_o_q;
        pop        = 1'b0;
        emit       = 1'b0;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    pop                = 1'b1;
                    emit               = 1'b1;
                    strobe_d           = 1'b1;
                    state_d            = RUN;
                    phase_d            = '0;
                    cnt_d              = '0;
                    {cur_e_d, cur_o_d} = fifo_head;
                end
            end
            RUN: begin
                emit    = 1'b1;
                phase_d = phase_q + LUT_AW'(PHASE_STEP);
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SPS - 1)) begin
                    if (en && !fifo_empty) begin
                        // Phase keeps running across the symbol boundary.
                        pop                = 1'b1;
                        strobe_d           = 1'b1;
                        cnt_d              = '0;
                        {cur_e_d, cur_o_d} = fifo_head;
                    end else begin
                        emit       = 1'b0;
                        state_d    = IDLE;
                        phase_d    = '0;
                        cnt_d      = '0;
                        underrun_d = en;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample generation for the value the next edge will present
    // ------------------------------------------------------------------
    logic [LUT_AW-1:0]        cos_idx;
    logic signed [DATA_W-1:0] sin_val;
    logic signed [DATA_W-1:0] cos_val;
    logic signed [DATA_W-1:0] i_d;
    logic signed [DATA_W-1:0] q_d;
    logic signed [DATA_W:0]   sum_d;

    always_comb begin
        cos_idx = phase_d + LUT_AW'(LUT_N / 4);
        sin_val = sin_lut[phase_d];
        cos_val = sin_lut[cos_idx];
        i_d     = '0;
        q_d     = '0;
        if (emit) begin
            i_d = cur_e_d ? sin_val : -sin_val;
            q_d = cur_o_d ? cos_val : -cos_val;
        end
        sum_d = {i_d[DATA_W-1], i_d} + {q_d[DATA_W-1], q_d};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            phase_q    <= '0;
            cnt_q      <= '0;
            cur_e_q    <= 1'b0;
            cur_o_q    <= 1'b0;
            I_out      <= '0;
            Q_out      <= '0;
            data_out   <= '0;
            sym_strobe <= 1'b0;
            active     <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            cur_e_q    <= cur_e_d;
            cur_o_q    <= cur_o_d;
            I_out      <= i_d;
            Q_out      <= q_d;
            data_out   <= sum_d;
            sym_strobe <= strobe_d;
            active     <= emit;
            underrun   <= underrun_d;
        end
    end

endmodule

// File: doc/qpsk_modulator_stream.md
Name: qpsk_modulator_stream

Overview:
- Parametrised streaming QPSK modulator.
- Accepts a serial bit stream over a valid/ready handshake and pairs the bits into (E, O) symbols.
- Buffers symbols in a small FIFO and emits I, Q and I+Q carrier samples from a phase-continuous sine/cosine LUT for SPS clocks per symbol.
- Sits between the bit source (framer/PRBS) and the DAC/sample sink; replaces free-running, fixed-size modulators with a back-pressured, gap-free symbol stream.

Parameters:
- DATA_W, 12: signed sample width of I_out/Q_out. AMP < 2^(DATA_W-1) is required.
- AMP, 1000: carrier peak amplitude.
- LUT_AW, 7: log2 of LUT entries per carrier period (128).
- PHASE_STEP, 1: LUT index increment per clock.
- SPS, 128: samples per symbol; must be ≥ 2.
- FIFO_DEPTH, 4: symbol FIFO entries; must be ≥ 1.

Ports:
- Clk  in  1: sample clock. One clock domain only; reset is asynchronous and active-high.
- Rst  in  1: asynchronous active-high reset.
- bit_in  in  1: serial data bit.
- bit_valid  in  1: bit_in is valid.
- bit_ready  out  1: block accepts bit_in this cycle.
- en  in  1: modulation enable.
- I_out  out  DATA_W: signed in-phase sample.
- Q_out  out  DATA_W: signed quadrature sample.
- data_out  out  DATA_W+1: signed I_out+Q_out.
- sym_strobe  out  1: high while sample 0 of a symbol is on the outputs.
- active  out  1: outputs carry symbol samples.
- underrun  out  1: one-cycle pulse when the stream stops for lack of data.
- fifo_level  out  $clog2(FIFO_DEPTH+1): symbols buffered.

Behaviour:
- LUT contents:
  - sin[k] = round(AMP·sin(2πk/2^LUT_AW)); cos[k] = sin[(k + 2^(LUT_AW-2)) mod 2^LUT_AW].
  - Content is built at elaboration. Quarter-wave storage is permitted if the outputs are identical.
- Bit pairing and FIFO push:
  - A bit is accepted on a rising Clk with bit_valid && bit_ready.
  - The first accepted bit of a pair is E (I sign); the second is O (Q sign).
  - The pair is pushed into the FIFO on the edge that accepts O.
  - A half-pair (E held, O pending) persists indefinitely.
- Ready rule: bit_ready = !(fifo_level == FIFO_DEPTH). A pop in the same cycle does not lift the full state for that cycle's push.
- Simultaneous push and pop: fifo_level is unchanged.
- FSM states: IDLE and RUN.
- IDLE:
  - I_out = Q_out = data_out = 0; active = 0; phase index = 0; sym_cnt = 0.
  - If en && fifo_level > 0: pop a symbol, load its sample 0 into the output registers, assert sym_strobe, set active = 1, go to RUN.
- RUN:
  - Each edge: sym_cnt++ and phase = (phase + PHASE_STEP) mod 2^LUT_AW.
  - I_out = E ? sin[phase] : -sin[phase]; Q_out = O ? cos[phase] : -cos[phase].
  - data_out = sign-extended I_out + Q_out. No saturation is needed because |sum| ≤ 2·AMP fits DATA_W+1.
- End of symbol (edge where sym_cnt == SPS-1):
  - If en && FIFO nonempty: pop the next symbol, sym_cnt = 0, phase continues (no reset), sym_strobe.
  - Otherwise go to IDLE with outputs zeroed on that edge. Pulse underrun for 1 cycle only if en == 1 and the FIFO is empty.
- Each symbol occupies exactly SPS consecutive output cycles. Back-to-back symbols have zero gap.
- Latency: the first output sample appears on the edge following the cycle in which en && nonempty is sampled in IDLE.
- en deasserted mid-symbol: the current symbol completes all SPS samples, no further pops occur, underrun stays 0, and FIFO contents are retained.
- Rst (asynchronous, any time):
  - State = IDLE; FIFO emptied; half-pair discarded (next bit is E); phase = 0; sym_cnt = 0.
  - All outputs are 0, except bit_ready = 1.

Test Plan:
- Assert Rst asynchronously between edges during RUN → outputs 0 immediately, bit_ready = 1, fifo_level = 0, active = 0.
- en = 1; push bits 1,1 → sample 0: I = 0, Q = 1000, data_out = 1000, sym_strobe = 1. Sample 32: I = 1000, Q = 0. After 128 samples: IDLE, outputs 0, underrun pulses once.
- Push 0,1 then 1,0 with en = 1 → first symbol sample 0: I = 0, Q = 1000. Exactly 128 cycles later, second symbol sample 0: Q = -1000, sym_strobe high, no idle cycle between symbols.
- en = 0; offer 10 valid bits → 8 accepted, fifo_level = 4, bit_ready = 0. Raise en → 4 symbols stream gap-free; bit_ready rises the cycle after the first pop.
- Reset at sample 50 of a symbol with a half-pair (bit 0) held → FIFO empty, half-pair discarded. Then push 1,0 → I positive (+sin), Q negative (-cos).
- Drop en at sample 60 of symbol 1 with 2 symbols queued → samples 60..127 still emitted, then IDLE, underrun = 0, fifo_level = 2.
